// File: rtl/stepper_move_ctrl.sv
// ---------------------------------------------------------------------------
// stepper_move_ctrl
//
// Purpose:
//   Motion controller for a 4-phase unipolar stepper output stage. It accepts
//   move commands (direction + step count) over a valid/ready handshake. Each
//   move runs a trapezoidal speed profile: accelerate, cruise, decelerate.
//   The block drives the one-hot coil pattern directly and keeps the signed
//   absolute position.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  high only while idle; accept = cmd_valid & cmd_ready
//   cmd_dir    in   1 = forward, 0 = reverse
//   cmd_steps  in   number of steps to move (STEPS_W bits)
//   abort      in   stop the current move immediately (ignored when idle)
//   busy       out  a move is in progress
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse when a move is aborted
//   pos        out  signed 32-bit absolute position, wraps
//   AB         out  one-hot coil drive pattern
//
// Optional feature (macro HOLD_RELEASE_EN):
//   After IDLE_TIMEOUT cycles in IDLE the coils are released (AB = 0000).
//   The phase is kept internally and is re-energised one cycle after the
//   next nonzero move is accepted. Without the macro the last phase is held
//   while idle.
// ---------------------------------------------------------------------------
module stepper_move_ctrl #(
    parameter int unsigned START_DIV = 200_000,
    parameter int unsigned MIN_DIV   = 50_000,
    parameter int unsigned RAMP_STEP = 25_000,
    parameter int unsigned STEPS_W   = 16
`ifdef HOLD_RELEASE_EN
    ,
    parameter int unsigned IDLE_TIMEOUT = 50_000_000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [31:0]        pos,
    output logic [3:0]         AB
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    localparam logic [31:0]        START_C  = START_DIV;
    localparam logic [31:0]        MIN_C    = MIN_DIV;
    localparam logic [31:0]        RAMP_C   = RAMP_STEP;
    localparam logic [STEPS_W-1:0] ONE_STEP = 1;

    state_t             state_q, state_d;
    logic [31:0]        div_q, div_d;
    logic [31:0]        timer_q, timer_d;
    logic [STEPS_W-1:0] remaining_q, remaining_d;
    logic [STEPS_W-1:0] accel_cnt_q, accel_cnt_d;
    logic               dir_q, dir_d;
    logic [3:0]         phase_q, phase_d;
    logic [31:0]        pos_q, pos_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [3:0]         ab_q, ab_d;

    logic               step_evt;
    logic [STEPS_W-1:0] rem_after;
    logic [31:0]        div_up;

`ifdef HOLD_RELEASE_EN
    localparam logic [31:0] IDLE_C = IDLE_TIMEOUT;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        released_q, released_d;
`endif

    // Next-state logic: command accept, step timing, speed profile and abort.
    // A step that lands on the same cycle as abort is completed before the
    // abort takes effect; a step that finishes the move reports done instead,
    // so done and aborted can never pulse together.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        accel_cnt_d = accel_cnt_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        pos_d       = pos_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        step_evt    = (state_q != IDLE) && (timer_q == div_q - 32'd1);
        rem_after   = remaining_q - ONE_STEP;
        div_up      = div_q + RAMP_C;

        if (state_q == IDLE) begin
            if (cmd_valid && cmd_ready_q) begin
                if (cmd_steps == '0) begin
                    done_d = 1'b1;
                end else begin
                    dir_d       = cmd_dir;
                    remaining_d = cmd_steps;
                    div_d       = START_C;
                    timer_d     = 32'd0;
                    accel_cnt_d = '0;
                    state_d     = ACCEL;
                end
            end
        end else begin
            timer_d = timer_q + 32'd1;
            if (step_evt) begin
                phase_d     = dir_q ? {phase_q[2:0], phase_q[3]}
                                    : {phase_q[0], phase_q[3:1]};
                pos_d       = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                remaining_d = rem_after;
                timer_d     = 32'd0;
                if (rem_after == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (rem_after <= accel_cnt_q) begin
                    // Start braking once the steps left equal the ramp-up
                    // steps taken, so the move ends back at start speed.
                    state_d     = DECEL;
                    div_d       = (div_up > START_C) ? START_C : div_up;
                    accel_cnt_d = (accel_cnt_q == '0) ? '0 : accel_cnt_q - ONE_STEP;
                end else if (state_q == ACCEL) begin
                    if (div_q > MIN_C) begin
                        div_d       = (div_q - MIN_C > RAMP_C) ? div_q - RAMP_C : MIN_C;
                        accel_cnt_d = accel_cnt_q + ONE_STEP;
                    end else begin
                        state_d = CRUISE;
                    end
                end
            end
            if (abort && !done_d) begin
                state_d   = IDLE;
                aborted_d = 1'b1;
                timer_d   = 32'd0;
            end
        end

        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
    end

`ifdef HOLD_RELEASE_EN
    // Idle timer: counts cycles spent idle and saturates at the timeout; the
    // coils are released once it is reached and re-energised when a move
    // leaves IDLE.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_d != IDLE) begin
            idle_cnt_d = 32'd0;
        end else if (idle_cnt_q < IDLE_C) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
        released_d = (state_d == IDLE) && (idle_cnt_d >= IDLE_C);
        ab_d       = released_d ? 4'b0000 : phase_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= 32'd0;
            released_q <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            released_q <= released_d;
        end
    end
`else
    // Holding torque: the coil output always follows the stored phase.
    always_comb begin
        ab_d = phase_d;
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= START_C;
            timer_q     <= 32'd0;
            remaining_q <= '0;
            accel_cnt_q <= '0;
            dir_q       <= 1'b1;
            phase_q     <= 4'b0001;
            pos_q       <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            ab_q        <= 4'b0001;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            accel_cnt_q <= accel_cnt_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            cmd_ready_q <= cmd_ready_d;
            ab_q        <= ab_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pos       = pos_q;
    assign AB        = ab_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stepper_move_ctrl
//
// Self-checking bench for stepper_move_ctrl with START_DIV=8, MIN_DIV=4,
// RAMP_STEP=2. Each scenario task pushes the expected step/done/aborted
// events (phase, position, cycles since the previous reference point) to a
// queue; a monitor pops and compares them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_stepper_move_ctrl;

    localparam int EV_STEP  = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    typedef struct {
        int          kind;
        logic [3:0]  ab;
        logic [31:0] pos;
        int          gap;
    } evt_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] pos;
    logic [3:0]  AB;

    evt_t exp_q[$];
    int   total;
    int   bad;
    int   cyc;
    int   ref_cyc;
    int   gap;
    logic acc_seen;
    logic fire;
    logic [3:0] prev_ab;
    bit   mon_en;
    evt_t e;

    stepper_move_ctrl #(
        .START_DIV(8),
        .MIN_DIV(4),
        .RAMP_STEP(2),
        .STEPS_W(16)
`ifdef HOLD_RELEASE_EN
        ,
        .IDLE_TIMEOUT(20)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps),
        .abort(abort),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .pos(pos),
        .AB(AB)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: the accept is sampled on the edge, outputs 1 unit
    // later. Gaps are measured from the accept edge or the previous step.
    always begin
        @(posedge clk);
        cyc      = cyc + 1;
        acc_seen = cmd_valid && cmd_ready && rst_n;
        #1;
        if (mon_en) begin
            if (acc_seen) ref_cyc = cyc;
            for (int k = 0; k < 3; k++) begin
                if (k == EV_STEP)
                    fire = (AB != prev_ab) && (AB != 4'b0000) && (prev_ab != 4'b0000);
                else if (k == EV_DONE)
                    fire = done;
                else
                    fire = aborted;
                if (fire) begin
                    total = total + 1;
                    gap = cyc - ref_cyc;
                    if (k == EV_STEP) ref_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        bad = bad + 1;
                        $display("[TB] FAIL scoreboard_unexpected: got kind=%0d AB=%b pos=%0d gap=%0d, required no event",
                                 k, AB, $signed(pos), gap);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.ab !== AB || e.pos !== pos || e.gap != gap ||
                            (k != EV_STEP && busy !== 1'b0)) begin
                            bad = bad + 1;
                            $display("[TB] FAIL scoreboard_event: got kind=%0d AB=%b pos=%0d gap=%0d busy=%b, required kind=%0d AB=%b pos=%0d gap=%0d busy=%0d",
                                     k, AB, $signed(pos), gap, busy, e.kind, e.ab, $signed(e.pos), e.gap,
                                     (k == EV_STEP) ? 1 : 0);
                        end
                    end
                end
            end
        end
        prev_ab = AB;
    end

    function automatic evt_t mk(input int kind, input logic [3:0] ab, input int p, input int g);
        evt_t r;
        r.kind = kind;
        r.ab   = ab;
        r.pos  = p;
        r.gap  = g;
        return r;
    endfunction

    task automatic start_cmd(input logic dir, input int steps);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps[15:0];
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total = total + 1;
        if (AB !== 4'b0001 || pos !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
            aborted !== 1'b0 || cmd_ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL reset_values: got AB=%b pos=%0d busy=%b done=%b aborted=%b ready=%b, required 0001 0 0 0 0 1",
                     AB, pos, busy, done, aborted, cmd_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total = total + 1;
        if (AB !== 4'b0001 || pos !== 32'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL reset_release: got AB=%b pos=%0d busy=%b ready=%b, required 0001 0 0 1",
                     AB, pos, busy, cmd_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_move_fwd6();
        bit ok;
        exp_q.push_back(mk(EV_STEP, 4'b0010, 1, 8));
        exp_q.push_back(mk(EV_STEP, 4'b0100, 2, 6));
        exp_q.push_back(mk(EV_STEP, 4'b1000, 3, 4));
        exp_q.push_back(mk(EV_STEP, 4'b0001, 4, 4));
        exp_q.push_back(mk(EV_STEP, 4'b0010, 5, 6));
        exp_q.push_back(mk(EV_STEP, 4'b0100, 6, 8));
        exp_q.push_back(mk(EV_DONE, 4'b0100, 6, 0));
        start_cmd(1'b1, 6);
        total = total + 1;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            bad = bad + 1;
            $display("[TB] FAIL fwd6_busy: got busy=%b ready=%b, required 1 0", busy, cmd_ready);
        end
        drain(100, ok);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("[TB] FAIL fwd6_complete: got pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        total = total + 1;
        if (pos !== 32'd6 || AB !== 4'b0100 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL fwd6_final: got pos=%0d AB=%b busy=%b done=%b ready=%b, required 6 0100 0 0 1",
                     $signed(pos), AB, busy, done, cmd_ready);
        end
    endtask

    task automatic test_move_rev2();
        bit ok;
        exp_q.push_back(mk(EV_STEP, 4'b0010, 5, 8));
        exp_q.push_back(mk(EV_STEP, 4'b0001, 4, 6));
        exp_q.push_back(mk(EV_DONE, 4'b0001, 4, 0));
        start_cmd(1'b0, 2);
        drain(60, ok);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("[TB] FAIL rev2_complete: got pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        total = total + 1;
        if (pos !== 32'd4 || AB !== 4'b0001) begin
            bad = bad + 1;
            $display("[TB] FAIL rev2_final: got pos=%0d AB=%b, required 4 0001", $signed(pos), AB);
        end
    endtask

    task automatic test_zero_steps();
        bit ok;
        exp_q.push_back(mk(EV_DONE, 4'b0001, 4, 0));
        start_cmd(1'b1, 0);
        total = total + 1;
        if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || AB !== 4'b0001 || pos !== 32'd4) begin
            bad = bad + 1;
            $display("[TB] FAIL zero_accept: got done=%b busy=%b ready=%b AB=%b pos=%0d, required 1 0 1 0001 4",
                     done, busy, cmd_ready, AB, $signed(pos));
        end
        drain(5, ok);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("[TB] FAIL zero_done: got pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        total = total + 1;
        if (done !== 1'b0 || busy !== 1'b0 || AB !== 4'b0001 || pos !== 32'd4) begin
            bad = bad + 1;
            $display("[TB] FAIL zero_after: got done=%b busy=%b AB=%b pos=%0d, required 0 0 0001 4",
                     done, busy, AB, $signed(pos));
        end
    endtask

    task automatic test_abort();
        bit ok;
        exp_q.push_back(mk(EV_STEP,  4'b0010, 5, 8));
        exp_q.push_back(mk(EV_STEP,  4'b0100, 6, 6));
        exp_q.push_back(mk(EV_ABORT, 4'b0100, 6, 3));
        start_cmd(1'b1, 10);
        repeat (16) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total = total + 1;
        if (aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL abort_pulse: got aborted=%b done=%b busy=%b ready=%b, required 1 0 0 1",
                     aborted, done, busy, cmd_ready);
        end
        drain(5, ok);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("[TB] FAIL abort_events: got pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (12) @(negedge clk);
        total = total + 1;
        if (aborted !== 1'b0 || pos !== 32'd6 || AB !== 4'b0100 || cmd_ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL abort_hold: got aborted=%b pos=%0d AB=%b ready=%b, required 0 6 0100 1",
                     aborted, $signed(pos), AB, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_q.push_back(mk(EV_STEP, 4'b0010, 5, 8));
        exp_q.push_back(mk(EV_STEP, 4'b0001, 4, 6));
        exp_q.push_back(mk(EV_STEP, 4'b1000, 3, 8));
        exp_q.push_back(mk(EV_DONE, 4'b1000, 3, 0));
        start_cmd(1'b0, 3);
        repeat (10) @(negedge clk);
        total = total + 1;
        if (cmd_ready !== 1'b0) begin
            bad = bad + 1;
            $display("[TB] FAIL busy_ready: got ready=%b, required 0", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        drain(60, ok);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("[TB] FAIL ignore_cmd: got pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (15) @(negedge clk);
        total = total + 1;
        if (pos !== 32'd3 || AB !== 4'b1000 || busy !== 1'b0) begin
            bad = bad + 1;
            $display("[TB] FAIL ignore_final: got pos=%0d AB=%b busy=%b, required 3 1000 0",
                     $signed(pos), AB, busy);
        end
    endtask

    task automatic test_reset_mid_move();
        bit ok;
        exp_q.push_back(mk(EV_STEP, 4'b0001, 4, 8));
        start_cmd(1'b1, 4);
        repeat (10) @(negedge clk);
        ok = (exp_q.size() == 0);
        total = total + 1;
        if (!ok || busy !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL midmove_state: got pending=%0d busy=%b, required 0 1", exp_q.size(), busy);
            exp_q.delete();
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total = total + 1;
        if (AB !== 4'b0001 || pos !== 32'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL async_reset: got AB=%b pos=%0d busy=%b ready=%b, required 0001 0 0 1",
                     AB, $signed(pos), busy, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_hold();
        bit ok;
        repeat (40) @(negedge clk);
`ifdef HOLD_RELEASE_EN
        total = total + 1;
        if (AB !== 4'b0000) begin
            bad = bad + 1;
            $display("[TB] FAIL hold_release: got AB=%b, required 0000", AB);
        end
`else
        total = total + 1;
        if (AB !== 4'b0001) begin
            bad = bad + 1;
            $display("[TB] FAIL hold_torque: got AB=%b, required 0001", AB);
        end
`endif
        exp_q.push_back(mk(EV_STEP, 4'b0010, 1, 8));
        exp_q.push_back(mk(EV_DONE, 4'b0010, 1, 0));
        start_cmd(1'b1, 1);
        total = total + 1;
        if (AB !== 4'b0001 || busy !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL hold_reenergise: got AB=%b busy=%b, required 0001 1", AB, busy);
        end
        drain(40, ok);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("[TB] FAIL hold_step: got pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        ref_cyc   = 0;
        mon_en    = 1'b0;
        prev_ab   = 4'b0001;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd0;
        abort     = 1'b0;
        rst_n     = 1'b1;
        test_reset();
        test_move_fwd6();
        test_move_rev2();
        test_zero_steps();
        test_abort();
        test_back_to_back();
        test_reset_mid_move();
        test_hold();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
